// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard FSM arbitrating memory freeze, load-use stall and branch flush.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_Aa,
    input  logic [4:0]       id_Ab,
    input  logic             id_uses_Ab,
    input  logic             id_BrTaken,
    input  logic             ex_MemToReg,
    input  logic             ex_RegWrite,
    input  logic [4:0]       ex_Aw,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eff_valid, hz, br;

    // The instruction behind a taken branch is dead in FLUSH; LDSTALL masks hz so one load stalls once.
    always_comb begin
        eff_valid = id_valid & (state_q != FLUSH);
        hz = eff_valid & ex_MemToReg & ex_RegWrite & (ex_Aw != 5'd31) &
             ((ex_Aw == id_Aa) | (id_uses_Ab & (ex_Aw == id_Ab))) & (state_q != LDSTALL);
        br = eff_valid & id_BrTaken;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = (state_q == FLUSH);
        state_d     = RUN;
        if (!reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b0;
            state_d     = MEMWAIT;
        end else if (hz) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LDSTALL;
        end else if (br) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b0;
            state_d     = FLUSH;
        end
    end

    assign cnt_d       = (!pc_en && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    assign state       = state_q;
    assign stall_count = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors feed a scoreboard queue; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset, id_valid, id_uses_Ab, id_BrTaken, ex_MemToReg, ex_RegWrite, mem_busy;
    logic [4:0] id_Aa, id_Ab, ex_Aw;
    logic pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0] state;
    logic [15:0] stall_count;
    logic pc_en2, ifid_en2, ifid_flush2, idex_bubble2;
    logic [1:0] state2;
    logic [1:0] stall_count2;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] eo;
        int         st;
        int         cnt;
        int         c2;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_Aa(id_Aa), .id_Ab(id_Ab),
        .id_uses_Ab(id_uses_Ab), .id_BrTaken(id_BrTaken), .ex_MemToReg(ex_MemToReg),
        .ex_RegWrite(ex_RegWrite), .ex_Aw(ex_Aw), .mem_busy(mem_busy), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .state(state), .stall_count(stall_count)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_Aa(id_Aa), .id_Ab(id_Ab),
        .id_uses_Ab(id_uses_Ab), .id_BrTaken(id_BrTaken), .ex_MemToReg(ex_MemToReg),
        .ex_RegWrite(ex_RegWrite), .ex_Aw(ex_Aw), .mem_busy(mem_busy), .pc_en(pc_en2),
        .ifid_en(ifid_en2), .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
        .state(state2), .stall_count(stall_count2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_en", int'(pc_en), int'(e.eo[3]));
            chk("ifid_en", int'(ifid_en), int'(e.eo[2]));
            chk("ifid_flush", int'(ifid_flush), int'(e.eo[1]));
            chk("idex_bubble", int'(idex_bubble), int'(e.eo[0]));
            chk("state", int'(state), e.st);
            chk("stall_count", int'(stall_count), e.cnt);
            if (e.c2 >= 0) chk("stall_count_w2", int'(stall_count2), e.c2);
        end
    end

    task automatic step(input logic r, input logic v, input logic [4:0] aa, input logic [4:0] ab,
                        input logic ub, input logic br, input logic mtr, input logic rw,
                        input logic [4:0] aw, input logic mb, input logic [3:0] eo,
                        input int st, input int cnt, input int c2);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; id_valid = v; id_Aa = aa; id_Ab = ab; id_uses_Ab = ub; id_BrTaken = br;
        ex_MemToReg = mtr; ex_RegWrite = rw; ex_Aw = aw; mem_busy = mb;
        e.eo = eo; e.st = st; e.cnt = cnt; e.c2 = c2;
        q.push_back(e);
    endtask

    task automatic idle(input logic [3:0] eo, input int st, input int cnt, input int c2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, st, cnt, c2);
    endtask

    initial begin
        reset = 0; id_valid = 0; id_Aa = 0; id_Ab = 0; id_uses_Ab = 0; id_BrTaken = 0;
        ex_MemToReg = 0; ex_RegWrite = 0; ex_Aw = 0; mem_busy = 0;
        repeat (2) @(posedge clk);
        // reset overrides busy, branch and hazard
        step(0, 1, 3, 0, 0, 1, 1, 1, 3, 1, 4'b0011, 0, 0, -1);
        idle(4'b1100, 0, 0, -1);
        // load-use on Rn: one bubble, then release
        step(1, 1, 3, 0, 0, 0, 1, 1, 3, 0, 4'b0001, 0, 0, -1);
        step(1, 1, 3, 0, 0, 0, 1, 1, 3, 0, 4'b1100, 1, 1, -1);
        step(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 4'b1100, 0, 1, -1);
        // XZR destination and unused Ab never stall
        step(1, 1, 31, 0, 0, 0, 1, 1, 31, 0, 4'b1100, 0, 1, -1);
        step(1, 1, 5, 4, 0, 0, 1, 1, 4, 0, 4'b1100, 0, 1, -1);
        // load-use through Ab
        step(1, 1, 5, 4, 1, 0, 1, 1, 4, 0, 4'b0001, 0, 1, -1);
        step(1, 1, 5, 4, 1, 0, 1, 1, 4, 0, 4'b1100, 1, 2, -1);
        // taken branch: flush, then bubble with decode ignored
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1110, 0, 2, -1);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1101, 2, 2, -1);
        idle(4'b1100, 0, 2, -1);
        // memory freeze with branch held, flush on release
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 0, 2, -1);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 3, 3, -1);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 3, 4, -1);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1110, 3, 5, -1);
        idle(4'b1101, 2, 5, -1);
        idle(4'b1100, 0, 5, -1);
        // hazard re-evaluated after a freeze
        step(1, 1, 3, 0, 0, 0, 1, 1, 3, 1, 4'b0000, 0, 5, -1);
        step(1, 1, 3, 0, 0, 0, 1, 1, 3, 0, 4'b0001, 3, 6, -1);
        step(1, 1, 3, 0, 0, 0, 1, 1, 3, 0, 4'b1100, 1, 7, -1);
        // reset in LDSTALL aborts it
        step(1, 1, 3, 0, 0, 0, 1, 1, 3, 0, 4'b0001, 0, 7, -1);
        step(0, 1, 3, 0, 0, 0, 1, 1, 3, 0, 4'b0011, 1, 8, -1);
        idle(4'b1100, 0, 0, 0);
        // saturation of the 2-bit counter
        for (int k = 0; k < 6; k++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, (k == 0) ? 0 : 3, k, (k > 3) ? 3 : k);
        idle(4'b1100, 3, 6, 3);
        idle(4'b1100, 0, 6, 3);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
